uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//   UART transmit sequencer driven by the baud tick of the shared baud generator.
//   - Accepts bytes over a valid/ready handshake into a one-entry holding register.
//   - Serialises each byte LSB-first as start / data / [parity] / stop bits, one bit per baud tick.
//   - Sits between the host byte source and the tx pin; the baud generator is instantiated alongside it.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, legal 5..8
//   STOP_BITS   1   stop bits per frame, legal 1 or 2
//   PARITY_ODD  0   0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined
// PORTS
//   clk        in   1          system clock
//   reset      in   1          asynchronous reset, active-high
//   baud_tick  in   1          one-cycle pulse per bit period, from the baud generator
//   tx_enable  in   1          1 = frames may start; 0 = hold idle once the current frame ends
//   in_data    in   DATA_BITS  byte to send
//   in_valid   in   1          in_data is valid
//   in_ready   out  1          holding register empty; transfer occurs when in_valid & in_ready
//   tx         out  1          serial line, idle high, registered
//   busy       out  1          FSM not in IDLE
//   tx_done    out  1          one-cycle pulse when the last stop bit period ends
// BEHAVIOUR
//   - Reset (async): tx=1, busy=0, tx_done=0, holding register empty (in_ready=1), FSM=IDLE, counters=0.
//   - in_ready = !hold_full, decoded from registered state only; no input-to-output combinational path.
//   - Handshake accept loads hold_data and sets hold_full at the clock edge.
//   - FSM states:
//     - IDLE -> START: on baud_tick & hold_full & tx_enable.
//       - Shifter <= hold_data; hold_full <= 0; tx <= 0.
//     - START -> DATA: on baud_tick. tx <= shifter[0]; bit_cnt <= 0.
//     - DATA: on each baud_tick, shift right and increment bit_cnt.
//       - Send the next bit while bit_cnt < DATA_BITS-1.
//       - After DATA_BITS ticks: go to PARITY if compiled in, else STOP with tx <= 1.
//     - PARITY: on baud_tick -> STOP; tx <= 1.
//     - STOP: stop_cnt counts STOP_BITS ticks. On the final tick:
//       - tx_done <= 1 for one cycle.
//       - If hold_full & tx_enable: go to START directly; tx <= 0, with no idle gap between frames.
//       - Else: go to IDLE.
//   - Timing:
//     - tx changes only on clock edges where baud_tick=1.
//     - Every bit lasts exactly one tick period.
//     - Frame length = 1 + DATA_BITS + [1] + STOP_BITS ticks.
//   - Latency: from accept in IDLE to start bit = wait for next baud_tick, plus 1 clk.
//   - Boundary cases:
//     - Simultaneous accept and shifter load in the same cycle cannot occur: in_ready=0 while hold_full.
//     - Hold is freed at the edge that starts a frame; in_ready rises the cycle after.
//     - in_valid during a frame with hold empty: accepted, then queued for back-to-back transmission.
//     - tx_enable is sampled only at frame start. Deasserting it mid-frame finishes the frame; hold keeps its byte.
//     - baud_tick arriving while IDLE with hold empty: no effect.
//     - Reset mid-frame: tx returns high immediately; the pending hold byte is discarded.
//     - Parameters outside their legal range: behaviour undefined; the bench does not exercise them.
// CONFIGURATION
//   - UART_TX_PARITY_EN defined:
//     - PARITY state is present.
//     - Parity bit = ^data for even (PARITY_ODD=0), ~^data for odd (PARITY_ODD=1).
//     - Parity is computed over the DATA_BITS bits latched at frame start.
//   - UART_TX_PARITY_EN undefined:
//     - No PARITY state and no parity logic.
//     - PARITY_ODD is ignored; DATA goes straight to STOP.
// TESTING  (baud_tick every 4 clks; DATA_BITS=8, STOP_BITS=1 unless stated)
//   - Reset, then idle 20 clks -> tx=1, busy=0, in_ready=1, tx_done=0 throughout.
//   - Send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clks; one tx_done pulse; busy low after.
//   - Send 0x3C then 0xC3 back-to-back -> second start bit immediately follows the first stop bit (no idle tick).
//     in_ready low while hold_full.
//   - With UART_TX_PARITY_EN:
//     - 0x07, PARITY_ODD=0 -> parity bit 1.
//     - 0x03, PARITY_ODD=1 -> parity bit 1.
//     - 11-bit frame.
//   - STOP_BITS=2, send 0xFF -> tx low 1 bit, then high for 10 bit periods; tx_done at end of second stop bit.
//   - Assert reset mid-DATA of 0x55 with a byte queued in hold -> tx=1 at once, in_ready=1; no output after release.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one-entry holding register feeding a start/data/[parity]/stop serialiser.
// Latency: frame starts on the first baud_tick after a byte is held (plus 1 clk); bits advance on baud_tick only.
// Backpressure: in_ready = !hold_full; a second byte may queue during a frame and is sent back-to-back.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_tx_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 tx_enable,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   // Reject configurations outside the supported frame formats at elaboration.
   if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_ctrl: parameter out of legal range");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   logic parity_q, parity_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   shifter_q, shifter_d;
   logic [DATA_BITS-1:0]   hold_data_q, hold_data_d;
   logic                   hold_full_q, hold_full_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   tx_q, tx_d;
   logic                   tx_done_q, tx_done_d;
   logic                   start_frame;

   // Outputs come straight from registered state; no input reaches an output combinationally.
   assign in_ready = !hold_full_q;
   assign tx       = tx_q;
   assign busy     = (state_q != S_IDLE);
   assign tx_done  = tx_done_q;

   // A frame launches from IDLE, or directly from the final stop tick when another byte waits.
   assign start_frame = baud_tick && hold_full_q && tx_enable &&
                        ((state_q == S_IDLE) ||
                         ((state_q == S_STOP) && (stop_cnt_q == LAST_STOP)));

   // Next-state: holding-register handshake, bit sequencing, and frame launch.
   always_comb begin
      state_d     = state_q;
      shifter_d   = shifter_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      tx_d        = tx_q;
      tx_done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      // Accept only into an empty hold; a frame launch needs a full hold, so the two never collide.
      if (in_valid && !hold_full_q) begin
         hold_data_d = in_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: ;
         S_START: begin
            if (baud_tick) begin
               tx_d      = shifter_q[0];
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               shifter_d = shifter_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q != LAST_BIT) begin
                  tx_d = shifter_q[1];
               end else begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = S_PARITY;
`else
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  tx_done_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Launch: move the held byte into the shifter, free the hold, drive the start bit.
      if (start_frame) begin
         state_d     = S_START;
         shifter_d   = hold_data_q;
         hold_full_d = 1'b0;
         tx_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d    = (^hold_data_q) ^ 1'(PARITY_ODD);
`endif
      end
   end

   // State register; reset forces the line idle and discards any held byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shifter_q   <= '0;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         tx_q        <= 1'b1;
         tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shifter_q   <= shifter_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_q        <= tx_d;
         tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame bit patterns, back-to-back queuing, tx_enable gating,
// two stop bits, optional parity, and asynchronous reset mid-frame. Baud tick every 4 clks.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       baud_tick = 1'b0;
   logic       tx_enable = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic       r0, t0, b0, d0;
   logic       r1, t1, b1, d1;
   logic       r2, t2, b2, d2;
   logic       rdy_s, tx_s, busy_s, done_s;
   int         total = 0;
   int         bad = 0;
   int         sel = 0;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_enable(tx_enable),
      .in_data(in_data), .in_valid(v0), .in_ready(r0), .tx(t0), .busy(b0), .tx_done(d0));

   uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_enable(tx_enable),
      .in_data(in_data), .in_valid(v1), .in_ready(r1), .tx(t1), .busy(b1), .tx_done(d1));

   uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_enable(tx_enable),
      .in_data(in_data), .in_valid(v2), .in_ready(r2), .tx(t2), .busy(b2), .tx_done(d2));

   always #5 clk = ~clk;

   always_comb begin
      rdy_s = r0; tx_s = t0; busy_s = b0; done_s = d0;
      case (sel)
         1: begin rdy_s = r1; tx_s = t1; busy_s = b1; done_s = d1; end
         2: begin rdy_s = r2; tx_s = t2; busy_s = b2; done_s = d2; end
         default: ;
      endcase
   end

   initial begin : baud_gen
      int c;
      c = 0;
      forever begin
         @(posedge clk);
         #1;
         c = (c + 1) % 4;
         baud_tick = (c == 0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input logic v);
      case (sel)
         1: v1 = v;
         2: v2 = v;
         default: v0 = v;
      endcase
   endtask

   task automatic send(input string tag, input logic [7:0] d);
      int w;
      w = 0;
      while (rdy_s !== 1'b1 && w < 200) begin step(); w++; end
      check({tag, "_rdy_before"}, rdy_s, 1);
      in_data = d;
      set_valid(1'b1);
      step();
      set_valid(1'b0);
      check({tag, "_rdy_held"}, rdy_s, 0);
   endtask

   // Waits for the start bit, then checks every clock of the frame plus the tx_done cycle.
   task automatic check_frame(input string tag, input logic [7:0] d, input int stops, input bit odd,
                              input bit b2b, input bit q_en, input logic [7:0] q_dat);
      logic bits [0:15];
      int   n;
      int   w;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
      n = 9;
      if (PAR) begin bits[n] = (^d) ^ odd; n++; end
      for (int s = 0; s < stops; s++) begin bits[n] = 1'b1; n++; end
      w = 0;
      while (tx_s !== 1'b0 && w < 100) begin step(); w++; end
      check({tag, "_start_seen"}, tx_s, 0);
      check({tag, "_rdy_freed"}, rdy_s, 1);
      for (int k = 0; k < n * 4; k++) begin
         if (k > 0) begin
            step();
            check({tag, "_done_low"}, done_s, 0);
         end
         check($sformatf("%s_tx_bit%0d_clk%0d", tag, k / 4, k % 4), tx_s, bits[k / 4]);
         check({tag, "_busy"}, busy_s, 1);
         if (q_en && k == 4) begin
            check({tag, "_rdy_q"}, rdy_s, 1);
            in_data = q_dat;
            set_valid(1'b1);
         end
         if (q_en && k == 5) begin
            set_valid(1'b0);
            check({tag, "_rdy_low_q"}, rdy_s, 0);
         end
      end
      step();
      check({tag, "_done_pulse"}, done_s, 1);
      check({tag, "_tx_after"}, tx_s, b2b ? 0 : 1);
      check({tag, "_busy_after"}, busy_s, b2b ? 1 : 0);
   endtask

   initial begin
      // Reset state, then quiet idle.
      sel = 0;
      step(); step(); step();
      check("rst_tx", t0, 1);
      check("rst_busy", b0, 0);
      check("rst_rdy", r0, 1);
      check("rst_done", d0, 0);
      check("rst_tx1", t1, 1);
      check("rst_rdy1", r1, 1);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_tx", t0, 1);
         check("idle_busy", b0, 0);
         check("idle_rdy", r0, 1);
         check("idle_done", d0, 0);
      end

      // Single frame.
      send("a5", 8'hA5);
      check_frame("a5", 8'hA5, 1, 1'b0, 1'b0, 1'b0, 8'h00);

      // Back-to-back: second byte queued during the first frame.
      send("3c", 8'h3C);
      check_frame("3c", 8'h3C, 1, 1'b0, 1'b1, 1'b1, 8'hC3);
      check_frame("c3", 8'hC3, 1, 1'b0, 1'b0, 1'b0, 8'h00);

      // tx_enable low: byte sits in hold, line stays idle until enabled.
      tx_enable = 1'b0;
      send("en", 8'h5A);
      for (int i = 0; i < 24; i++) begin
         step();
         check("en_off_tx", t0, 1);
         check("en_off_busy", b0, 0);
         check("en_off_rdy", r0, 0);
      end
      tx_enable = 1'b1;
      check_frame("en", 8'h5A, 1, 1'b0, 1'b0, 1'b0, 8'h00);

      if (PAR) begin
         send("par_even", 8'h07);
         check_frame("par_even", 8'h07, 1, 1'b0, 1'b0, 1'b0, 8'h00);
         sel = 2;
         send("par_odd", 8'h03);
         check_frame("par_odd", 8'h03, 1, 1'b1, 1'b0, 1'b0, 8'h00);
      end

      // Two stop bits.
      sel = 1;
      send("stop2", 8'hFF);
      check_frame("stop2", 8'hFF, 2, 1'b0, 1'b0, 1'b0, 8'h00);

      // Reset mid-data with a byte queued.
      sel = 0;
      send("rst55", 8'h55);
      for (int w = 0; w < 100 && t0 !== 1'b0; w++) step();
      check("rst55_start", t0, 0);
      for (int i = 0; i < 8; i++) step();
      send("rstq", 8'hAA);
      check("rst55_busy_pre", b0, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_tx", t0, 1);
      check("rst_mid_rdy", r0, 1);
      check("rst_mid_busy", b0, 0);
      check("rst_mid_done", d0, 0);
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         check("post_rst_tx", t0, 1);
         check("post_rst_busy", b0, 0);
         check("post_rst_rdy", r0, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
